memory_arbiter: RTL and testbench

//  Single-port memory arbiter directly downstream of the request unit. Accepts instruction-fetch
//  (iren) and data read/write (dren/wren) requests, serialises them onto one RAM port with a

---
 rtl/arb_pkg.sv | 10 +
 rtl/arb_watchdog.sv | 33 +++
 rtl/memory_arbiter.sv | 178 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package arb_pkg;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} arb_state_t;
   typedef logic [DEF_ADDR_W-1:0] addr_t;
   typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
module arb_watchdog #(
   parameter int TIMEOUT = arb_pkg::DEF_TIMEOUT
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && cnt_q != LAST)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Asserted during the TIMEOUT-th cycle of an access; the FSM aborts on this edge.
   assign expired = enable && !clear && (cnt_q == LAST);
endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port, data first.
// Optional ARB_STATS_EN adds icount/dcount/stall_cnt statistics outputs.
module memory_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              iren,
   input  logic              dren,
   input  logic              wren,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              ihit,
   output logic              dhit,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload,
   output logic              err,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       icount,
   output logic [31:0]       dcount,
   output logic [31:0]       stall_cnt
`endif
);
   arb_state_t        state_q, state_d;
   logic              op_wr_q, op_wr_d;
   logic              op_data_q, op_data_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] iload_q, iload_d;
   logic [DATA_W-1:0] dload_q, dload_d;
   logic              busy, expired;

   assign busy = (state_q == IACC) || (state_q == DACC);

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (!busy),
      .enable  (busy),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         op_wr_q   <= 1'b0;
         op_data_q <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         iload_q   <= '0;
         dload_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_wr_q   <= op_wr_d;
         op_data_q <= op_data_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         iload_q   <= iload_d;
         dload_q   <= dload_d;
      end
   end

   // ram_ready takes priority over the watchdog on the final allowed cycle.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wren || dren)
               state_d = DACC;
            else if (iren)
               state_d = IACC;
         end
         IACC, DACC: begin
            if (ram_ready)
               state_d = RESP;
            else if (expired) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_wr_d   = op_wr_q;
      op_data_d = op_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      iload_d   = iload_q;
      dload_d   = dload_q;
      if (state_q == IDLE) begin
         if (wren || dren) begin
            op_wr_d   = wren;
            op_data_d = 1'b1;
            addr_d    = daddr;
            wdata_d   = dstore;
         end else if (iren) begin
            op_wr_d   = 1'b0;
            op_data_d = 1'b0;
            addr_d    = iaddr;
         end
      end
      if (ram_ready && state_q == IACC)
         iload_d = ram_rdata;
      if (ram_ready && state_q == DACC && !op_wr_q)
         dload_d = ram_rdata;
   end

   always_comb begin
      ram_ren = 1'b0;
      ram_wen = 1'b0;
      ihit    = 1'b0;
      dhit    = 1'b0;
      case (state_q)
         IACC: ram_ren = 1'b1;
         DACC: begin
            ram_ren = !op_wr_q;
            ram_wen = op_wr_q;
         end
         RESP: begin
            dhit = op_data_q;
            ihit = !op_data_q;
         end
         default: ;
      endcase
   end

   assign err       = err_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign iload     = iload_q;
   assign dload     = dload_q;

`ifdef ARB_STATS_EN
   logic [31:0] icount_q, icount_d;
   logic [31:0] dcount_q, dcount_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      icount_d = icount_q + {31'd0, ihit};
      dcount_d = dcount_q + {31'd0, dhit};
      stall_d  = stall_q + {31'd0, busy};
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         icount_q <= '0;
         dcount_q <= '0;
         stall_q  <= '0;
      end else begin
         icount_q <= icount_d;
         dcount_q <= dcount_d;
         stall_q  <= stall_d;
      end
   end

   assign icount    = icount_q;
   assign dcount    = dcount_q;
   assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter (built with TIMEOUT=4).
module tb_memory_arbiter;
   typedef struct packed {
      logic        ihit;
      logic        dhit;
      logic        err;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] iload;
      logic [31:0] dload;
   } outs_t;

   typedef struct {
      logic        n_rst;
      logic        iren;
      logic        dren;
      logic        wren;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] ds;
      logic [31:0] rd;
      logic        rdy;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        n_rst, iren, dren, wren, ram_ready;
   logic [31:0] iaddr, daddr, dstore, ram_rdata;
   logic        ihit, dhit, err, ram_ren, ram_wen;
   logic [31:0] iload, dload, ram_addr, ram_wdata;
`ifdef ARB_STATS_EN
   logic [31:0] icount, dcount, stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .iren      (iren),
      .dren      (dren),
      .wren      (wren),
      .iaddr     (iaddr),
      .daddr     (daddr),
      .dstore    (dstore),
      .ihit      (ihit),
      .dhit      (dhit),
      .iload     (iload),
      .dload     (dload),
      .err       (err),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ready (ram_ready)
`ifdef ARB_STATS_EN
      ,
      .icount    (icount),
      .dcount    (dcount),
      .stall_cnt (stall_cnt)
`endif
   );

   function automatic outs_t o(logic ih, logic dh, logic er, logic rn, logic wn,
                               logic [31:0] ad, logic [31:0] wd,
                               logic [31:0] il, logic [31:0] dl);
      outs_t r;
      r.ihit = ih; r.dhit = dh; r.err = er; r.ren = rn; r.wen = wn;
      r.addr = ad; r.wdata = wd; r.iload = il; r.dload = dl;
      return r;
   endfunction

   function automatic vec_t v(logic rs, logic ir, logic dr, logic wr,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                              logic [31:0] rd, logic rdy, outs_t e);
      vec_t r;
      r.n_rst = rs; r.iren = ir; r.dren = dr; r.wren = wr;
      r.ia = ia; r.da = da; r.ds = ds; r.rd = rd; r.rdy = rdy; r.exp = e;
      return r;
   endfunction

   task automatic drive(logic rs, logic ir, logic dr, logic wr, logic [31:0] ia,
                        logic [31:0] da, logic [31:0] ds, logic [31:0] rd, logic rdy);
      n_rst = rs; iren = ir; dren = dr; wren = wr;
      iaddr = ia; daddr = da; dstore = ds; ram_rdata = rd; ram_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, outs_t e);
      outs_t a;
      a = o(ihit, dhit, err, ram_ren, ram_wen, ram_addr, ram_wdata, iload, dload);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got ih=%b dh=%b er=%b ren=%b wen=%b addr=%h wd=%h il=%h dl=%h want ih=%b dh=%b er=%b ren=%b wen=%b addr=%h wd=%h il=%h dl=%h",
                  name, a.ihit, a.dhit, a.err, a.ren, a.wen, a.addr, a.wdata, a.iload, a.dload,
                  e.ihit, e.dhit, e.err, e.ren, e.wen, e.addr, e.wdata, e.iload, e.dload);
      end
   endtask

   task automatic chk32(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   localparam logic [31:0] IL1 = 32'h1234_5678;
   localparam logic [31:0] DL1 = 32'hCAFE_F00D;
   localparam logic [31:0] IL2 = 32'h0BAD_C0DE;
   localparam logic [31:0] DL2 = 32'h1111_2222;
   localparam logic [31:0] WD  = 32'hDEAD_BEEF;

   vec_t tbl[21];

   initial begin
      // Each row: inputs present at an edge, outputs expected just after it.
      tbl[0]  = v(0,0,0,0, 0,0,0, 0,0,           o(0,0,0,0,0, 32'h0,   0,   0,   0));
      tbl[1]  = v(1,1,0,0, 32'h40,0,0, 0,0,      o(0,0,0,1,0, 32'h40,  0,   0,   0));
      tbl[2]  = v(1,1,0,0, 32'h40,0,0, 0,0,      o(0,0,0,1,0, 32'h40,  0,   0,   0));
      tbl[3]  = v(1,1,0,0, 32'h40,0,0, 0,0,      o(0,0,0,1,0, 32'h40,  0,   0,   0));
      tbl[4]  = v(1,1,0,0, 32'h40,0,0, IL1,1,    o(1,0,0,0,0, 32'h40,  0,   IL1, 0));
      tbl[5]  = v(1,0,0,0, 0,0,0, 0,0,           o(0,0,0,0,0, 32'h40,  0,   IL1, 0));
      tbl[6]  = v(1,1,1,0, 32'h80,32'h100,0, 0,0,o(0,0,0,1,0, 32'h100, 0,   IL1, 0));
      tbl[7]  = v(1,1,1,0, 32'h80,32'h100,0, DL1,1,o(0,1,0,0,0, 32'h100, 0, IL1, DL1));
      tbl[8]  = v(1,1,0,0, 32'h80,0,0, 0,0,      o(0,0,0,0,0, 32'h100, 0,   IL1, DL1));
      tbl[9]  = v(1,1,0,0, 32'h80,0,0, 0,0,      o(0,0,0,1,0, 32'h80,  0,   IL1, DL1));
      tbl[10] = v(1,1,0,0, 32'h80,0,0, IL2,1,    o(1,0,0,0,0, 32'h80,  0,   IL2, DL1));
      tbl[11] = v(1,0,0,0, 0,0,0, 0,0,           o(0,0,0,0,0, 32'h80,  0,   IL2, DL1));
      tbl[12] = v(1,0,1,1, 0,32'h8,WD, 0,0,      o(0,0,0,0,1, 32'h8,   WD,  IL2, DL1));
      tbl[13] = v(1,0,1,1, 0,32'h999,0, 0,0,     o(0,0,0,0,1, 32'h8,   WD,  IL2, DL1));
      tbl[14] = v(1,0,1,1, 0,32'h999,0, 32'h5555_5555,1, o(0,1,0,0,0, 32'h8, WD, IL2, DL1));
      tbl[15] = v(1,0,0,0, 0,0,0, 0,0,           o(0,0,0,0,0, 32'h8,   WD,  IL2, DL1));
      tbl[16] = v(1,0,0,0, 0,0,0, 32'h7777_7777,1, o(0,0,0,0,0, 32'h8,  WD,  IL2, DL1));
      tbl[17] = v(1,0,1,0, 0,32'h20,0, 0,0,      o(0,0,0,1,0, 32'h20,  0,   IL2, DL1));
      tbl[18] = v(1,0,0,0, 0,0,0, 0,0,           o(0,0,0,1,0, 32'h20,  0,   IL2, DL1));
      tbl[19] = v(1,0,0,0, 0,0,0, DL2,1,         o(0,1,0,0,0, 32'h20,  0,   IL2, DL2));
      tbl[20] = v(1,0,0,0, 0,0,0, 0,0,           o(0,0,0,0,0, 32'h20,  0,   IL2, DL2));

      drive(0,0,0,0, 0,0,0, 0,0);
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].n_rst, tbl[i].iren, tbl[i].dren, tbl[i].wren, tbl[i].ia,
               tbl[i].da, tbl[i].ds, tbl[i].rd, tbl[i].rdy);
         step();
         chk($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Watchdog: four cycles in IACC without ready, then err and back to IDLE.
      drive(1,1,0,0, 32'h200,0,0, 0,0);
      step(); chk("wd_enter", o(0,0,0,1,0, 32'h200, 0, IL2, DL2));
      step(); chk("wd_c2",    o(0,0,0,1,0, 32'h200, 0, IL2, DL2));
      step(); chk("wd_c3",    o(0,0,0,1,0, 32'h200, 0, IL2, DL2));
      step(); chk("wd_c4",    o(0,0,0,1,0, 32'h200, 0, IL2, DL2));
      drive(1,0,0,0, 0,0,0, 0,0);
      step(); chk("wd_err",   o(0,0,1,0,0, 32'h200, 0, IL2, DL2));
      drive(1,0,0,0, 0,0,0, 32'hFFFF_FFFF,1);
      step(); chk("wd_after", o(0,0,0,0,0, 32'h200, 0, IL2, DL2));

      // Reset in the middle of a fetch abandons it.
      drive(1,1,0,0, 32'h300,0,0, 0,0);
      step(); chk("rst_acc1", o(0,0,0,1,0, 32'h300, 0, IL2, DL2));
      step(); chk("rst_acc2", o(0,0,0,1,0, 32'h300, 0, IL2, DL2));
      drive(0,1,0,0, 32'h300,0,0, 0,0);
      step(); chk("rst_hit",  o(0,0,0,0,0, 32'h0, 0, 0, 0));
      drive(1,0,0,0, 0,0,0, 32'hABCD_0123,1);
      step(); chk("rst_noh1", o(0,0,0,0,0, 32'h0, 0, 0, 0));
      drive(1,0,0,0, 0,0,0, 0,0);
      step(); chk("rst_noh2", o(0,0,0,0,0, 32'h0, 0, 0, 0));

`ifdef ARB_STATS_EN
      chk32("stats_icount_rst", icount, 32'd0);
      chk32("stats_stall_rst", stall_cnt, 32'd0);
      // Three fetches then two loads, each with ready two cycles after the request.
      for (int k = 0; k < 5; k++) begin
         if (k < 3) drive(1,1,0,0, 32'h400 + k*4,0,0, 0,0);
         else       drive(1,0,1,0, 0,32'h500 + k*4,0, 0,0);
         step();
         drive(1,iren,dren,0, iaddr,daddr,0, 0,0);
         step();
         drive(1,iren,dren,0, iaddr,daddr,0, 32'h9000 + k,1);
         step();
         drive(1,0,0,0, 0,0,0, 0,0);
         step();
      end
      chk32("stats_icount", icount, 32'd3);
      chk32("stats_dcount", dcount, 32'd2);
      chk32("stats_stall", stall_cnt, 32'd10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "bench timeout");
   end
endmodule
